// File: rtl/m_bus_bridge_pkg.sv
// Shared encodings for the M-stage data-bus bridge: access sizes, exception codes,
// FSM states and the byte-lane helpers used at issue time.
package m_bus_bridge_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_DBE  = 5'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SZ_BYTE: return 4'b0001 << a;
      SZ_HALF: return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Stores replicate the datum into every lane so the slave only needs bus_be.
  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] d);
    case (size)
      SZ_BYTE: return {4{d[7:0]}};
      SZ_HALF: return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    return (size == SZ_HALF && a[0]) || (size == SZ_WORD && a != 2'b00);
  endfunction

endpackage

// File: rtl/m_bus_bridge_load_ext.sv
// Load-data extraction: picks the addressed byte/half lane of the bus word and
// sign- or zero-extends it to 32 bits.
module m_bus_bridge_load_ext (
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        sign,
  output logic [31:0] data
);
  import m_bus_bridge_pkg::*;

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    case (addr)
      2'd0:    lane_b = rdata[7:0];
      2'd1:    lane_b = rdata[15:8];
      2'd2:    lane_b = rdata[23:16];
      default: lane_b = rdata[31:24];
    endcase
    lane_h = addr[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SZ_BYTE: data = {{24{sign & lane_b[7]}}, lane_b};
      SZ_HALF: data = {{16{sign & lane_h[15]}}, lane_h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/m_bus_bridge.sv
// M-stage bus bridge: issues the registered memory op as a req/ack transaction,
// stalls the pipe while it is outstanding and resolves AdEL/AdES/DBE.
//
// state | meaning
// IDLE  | no transaction; a valid, aligned, unflushed op issues on this edge
// BUSY  | bus_req held with stable bus_* until ack or timeout
// DONE  | one cycle: load result / DBE presented, pipe released
module m_bus_bridge #(
  parameter int         TO_W     = 8,
  parameter logic [4:0] EXC_ADEL = m_bus_bridge_pkg::EXC_ADEL,
  parameter logic [4:0] EXC_ADES = m_bus_bridge_pkg::EXC_ADES,
  parameter logic [4:0] EXC_DBE  = m_bus_bridge_pkg::EXC_DBE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [1:0]  mem_size,
  input  logic        mem_sign,
  input  logic [31:0] addr_m,
  input  logic [31:0] wdata_m,
  input  logic [4:0]  exccode_in,
  input  logic        flush,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        stall_m,
  output logic [31:0] ld_data,
  output logic        ld_valid,
  output logic [4:0]  exccode_out,
  output logic [31:0] badvaddr
);
  import m_bus_bridge_pkg::*;

  // Down-counter spans 2**TO_W-1 BUSY cycles: loaded with 2**TO_W-2, expires at zero.
  localparam logic [TO_W-1:0] TO_LOAD = {{(TO_W-1){1'b1}}, 1'b0};
  localparam logic [TO_W-1:0] TO_ONE  = {{(TO_W-1){1'b0}}, 1'b1};

  state_e          state_q, state_d;
  logic            misalign, go, timeout;
  logic [TO_W-1:0] to_cnt_q;
  logic            req_q, we_q, sign_q, killed_q, dbe_q, ld_valid_q;
  logic [1:0]      size_q;
  logic [3:0]      be_q;
  logic [31:0]     addr_q, wdata_q, ld_data_q, ext_data;

  assign misalign = misaligned(mem_size, addr_m[1:0]);
  assign go       = (mem_rd | mem_wr) && (exccode_in == 5'd0) && !misalign && !flush;
  assign timeout  = (state_q == ST_BUSY) && !bus_ack && (to_cnt_q == '0);

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    stall_m = 1'b0;
    case (state_q)
      ST_IDLE: begin
        stall_m = go;
        if (go) state_d = ST_BUSY;
      end
      ST_BUSY: begin
        stall_m = 1'b1;
        if (bus_ack || timeout) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (reset) stall_m = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      size_q     <= '0;
      sign_q     <= 1'b0;
      to_cnt_q   <= '0;
      killed_q   <= 1'b0;
      dbe_q      <= 1'b0;
      ld_valid_q <= 1'b0;
      ld_data_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (go) begin
            req_q    <= 1'b1;
            we_q     <= mem_wr;
            addr_q   <= addr_m;
            be_q     <= byte_en(mem_size, addr_m[1:0]);
            wdata_q  <= store_lanes(mem_size, wdata_m);
            size_q   <= mem_size;
            sign_q   <= mem_sign;
            to_cnt_q <= TO_LOAD;
            killed_q <= 1'b0;
          end
        end
        ST_BUSY: begin
          // A flush never aborts the bus cycle; it only suppresses the load result.
          if (flush) killed_q <= 1'b1;
          if (bus_ack) begin
            req_q      <= 1'b0;
            ld_data_q  <= ext_data;
            ld_valid_q <= !we_q && !killed_q && !flush;
          end else if (timeout) begin
            req_q <= 1'b0;
            dbe_q <= 1'b1;
          end else begin
            to_cnt_q <= to_cnt_q - TO_ONE;
          end
        end
        ST_DONE: begin
          ld_valid_q <= 1'b0;
          dbe_q      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  m_bus_bridge_load_ext u_load_ext (
    .rdata (bus_rdata),
    .addr  (addr_q[1:0]),
    .size  (size_q),
    .sign  (sign_q),
    .data  (ext_data)
  );

  // Carried-in codes win over misalignment; DBE only appears in the DONE cycle.
  always_comb begin
    exccode_out = 5'd0;
    badvaddr    = 32'd0;
    if (state_q == ST_DONE) begin
      if (dbe_q) begin
        exccode_out = EXC_DBE;
        badvaddr    = addr_q;
      end
    end else if (state_q == ST_IDLE) begin
      if (exccode_in != 5'd0) begin
        exccode_out = exccode_in;
      end else if ((mem_rd | mem_wr) && misalign) begin
        exccode_out = mem_wr ? EXC_ADES : EXC_ADEL;
        badvaddr    = addr_m;
      end
    end
  end

  assign bus_req   = req_q;
  assign bus_we    = we_q;
  assign bus_addr  = {addr_q[31:2], 2'b00};
  assign bus_be    = be_q;
  assign bus_wdata = wdata_q;
  assign ld_data   = ld_data_q;
  assign ld_valid  = ld_valid_q;

endmodule

// File: tb/tb_m_bus_bridge.sv
// Self-checking bench for m_bus_bridge: directed vector table, hand sequences for
// flush/reset corners, and random ops checked against an arithmetic reference model.
module tb_m_bus_bridge;

  localparam int TO_W = 3;
  localparam int TMO  = (1 << TO_W) - 1;

  logic        clk = 1'b0;
  logic        reset, mem_rd, mem_wr, mem_sign, flush, bus_ack;
  logic [1:0]  mem_size;
  logic [31:0] addr_m, wdata_m, bus_rdata;
  logic [4:0]  exccode_in;
  logic        bus_req, bus_we, stall_m, ld_valid;
  logic [31:0] bus_addr, bus_wdata, ld_data, badvaddr;
  logic [3:0]  bus_be;
  logic [4:0]  exccode_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  m_bus_bridge #(.TO_W(TO_W)) dut (
    .clk(clk), .reset(reset), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_size(mem_size),
    .mem_sign(mem_sign), .addr_m(addr_m), .wdata_m(wdata_m), .exccode_in(exccode_in),
    .flush(flush), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .stall_m(stall_m), .ld_data(ld_data), .ld_valid(ld_valid),
    .exccode_out(exccode_out), .badvaddr(badvaddr)
  );

  // ack_delay = number of bus_req cycles without ack before the ack cycle.
  typedef struct {
    logic        rd, wr;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] addr, wdata;
    logic [4:0]  exc_in;
    logic [31:0] rdata;
    int          ack_delay;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata, exp_ld;
    logic [4:0]  exp_exc;
    int          exp_stall;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [1:0] size,
                              input logic sign, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [4:0] exc_in, input logic [31:0] rdata, input int ack_delay,
                              input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                              input logic [31:0] exp_ld, input logic [4:0] exp_exc, input int exp_stall);
    vec_t v;
    v.rd = rd; v.wr = wr; v.size = size; v.sign = sign; v.addr = addr; v.wdata = wdata;
    v.exc_in = exc_in; v.rdata = rdata; v.ack_delay = ack_delay; v.exp_be = exp_be;
    v.exp_wdata = exp_wdata; v.exp_ld = exp_ld; v.exp_exc = exp_exc; v.exp_stall = exp_stall;
    return v;
  endfunction

  // Reference: access of 2**size bytes at byte offset addr[1:0], computed arithmetically.
  function automatic vec_t model(input vec_t v);
    vec_t        r;
    int          nb, sh, nbits, busy;
    logic        mis, go;
    logic [63:0] val;
    r     = v;
    nb    = 1 << v.size;
    sh    = int'(v.addr[1:0]);
    mis   = (sh % nb) != 0;
    go    = (v.rd | v.wr) && (v.exc_in == 5'd0) && !mis;
    r.exp_be = 4'(((1 << nb) - 1) << sh);
    for (int i = 0; i < 4; i++) r.exp_wdata[8*i +: 8] = v.wdata[8*(i % nb) +: 8];
    nbits = 8 * nb;
    val   = ({32'd0, v.rdata} >> (8 * sh)) & ((64'd1 << nbits) - 64'd1);
    if (v.sign && val[nbits-1]) val = val - (64'd1 << nbits);
    r.exp_ld = val[31:0];
    busy = (v.ack_delay >= TMO) ? TMO : v.ack_delay + 1;
    if (v.exc_in != 5'd0)           r.exp_exc = v.exc_in;
    else if ((v.rd | v.wr) && mis)  r.exp_exc = v.wr ? 5'd5 : 5'd4;
    else if (go && v.ack_delay >= TMO) r.exp_exc = 5'd7;
    else                            r.exp_exc = 5'd0;
    r.exp_stall = go ? 1 + busy : 0;
    return r;
  endfunction

  task automatic run_op(input vec_t v, input int flush_cyc);
    bit go, acked, tmo, killed;
    int k, stalls;
    go = (v.exp_stall != 0);
    mem_rd = v.rd; mem_wr = v.wr; mem_size = v.size; mem_sign = v.sign;
    addr_m = v.addr; wdata_m = v.wdata; exccode_in = v.exc_in; flush = 1'b0; bus_ack = 1'b0;
    #1;
    stalls = int'(stall_m);
    chk("req_idle", 32'(bus_req), 32'd0);
    if (!go) begin
      chk("stall_nogo", 32'(stall_m), 32'd0);
      chk("exc_nogo", 32'(exccode_out), 32'(v.exp_exc));
      chk("badv_nogo", badvaddr,
          (v.exc_in == 5'd0 && (v.exp_exc == 5'd4 || v.exp_exc == 5'd5)) ? v.addr : 32'd0);
      @(posedge clk); #1;
      chk("req_after_nogo", 32'(bus_req), 32'd0);
    end else begin
      acked = 0; tmo = 0; killed = 0; k = 0;
      while (!acked && !tmo) begin
        @(posedge clk); #1;
        k++;
        bus_ack   = (k == v.ack_delay + 1);
        bus_rdata = bus_ack ? v.rdata : $urandom;
        flush     = (k == flush_cyc);
        if (flush) killed = 1;
        #1;
        chk("req_busy", 32'(bus_req), 32'd1);
        chk("we_busy", 32'(bus_we), 32'(v.wr));
        chk("addr_busy", bus_addr, {v.addr[31:2], 2'b00});
        chk("be_busy", 32'(bus_be), 32'(v.exp_be));
        if (v.wr) chk("wdata_busy", bus_wdata, v.exp_wdata);
        chk("ldv_busy", 32'(ld_valid), 32'd0);
        stalls += int'(stall_m);
        acked = bus_ack;
        tmo   = !bus_ack && (k == TMO);
      end
      @(posedge clk); #1;
      bus_ack = 1'b0; flush = 1'b0;
      #1;
      stalls += int'(stall_m);
      chk("req_done", 32'(bus_req), 32'd0);
      chk("ldv_done", 32'(ld_valid), 32'(v.rd && acked && !killed));
      if (v.rd && acked && !killed) chk("ld_data", ld_data, v.exp_ld);
      chk("exc_done", 32'(exccode_out), 32'(v.exp_exc));
      chk("badv_done", badvaddr, tmo ? v.addr : 32'd0);
      chk("stall_cycles", 32'(stalls), 32'(v.exp_stall));
      @(posedge clk); #1;
      chk("ldv_after", 32'(ld_valid), 32'd0);
    end
    mem_rd = 1'b0; mem_wr = 1'b0; exccode_in = 5'd0;
  endtask

  initial begin
    vec_t rv;
    int   op, fc;
    reset = 1'b1; mem_rd = 1'b0; mem_wr = 1'b0; mem_size = 2'd0; mem_sign = 1'b0;
    addr_m = '0; wdata_m = '0; exccode_in = '0; flush = 1'b0; bus_ack = 1'b0; bus_rdata = '0;

    //            rd wr size sign addr          wdata         exc   rdata         dly be       exp_wdata     exp_ld        exc  stall
    tbl[0]  = mk(1, 0, 2'd2, 0, 32'h0000_1004, 32'h0,        5'd0, 32'hDEAD_BEEF, 2, 4'b1111, 32'h0,        32'hDEAD_BEEF, 5'd0, 4);
    tbl[1]  = mk(1, 0, 2'd0, 1, 32'h0000_1003, 32'h0,        5'd0, 32'h80FF_7F01, 0, 4'b1000, 32'h0,        32'hFFFF_FF80, 5'd0, 2);
    tbl[2]  = mk(1, 0, 2'd0, 0, 32'h0000_1003, 32'h0,        5'd0, 32'h80FF_7F01, 0, 4'b1000, 32'h0,        32'h0000_0080, 5'd0, 2);
    tbl[3]  = mk(0, 1, 2'd1, 0, 32'h0000_2002, 32'h1234_ABCD, 5'd0, 32'h0,        1, 4'b1100, 32'hABCD_ABCD, 32'h0,        5'd0, 3);
    tbl[4]  = mk(1, 0, 2'd2, 0, 32'h0000_3002, 32'h0,        5'd0, 32'h0,        0, 4'b0000, 32'h0,        32'h0,        5'd4, 0);
    tbl[5]  = mk(0, 1, 2'd2, 0, 32'h0000_3001, 32'h5555_5555, 5'd0, 32'h0,        0, 4'b0000, 32'h0,        32'h0,        5'd5, 0);
    tbl[6]  = mk(1, 0, 2'd1, 1, 32'h0000_1002, 32'h0,        5'd0, 32'h80FF_7F01, 0, 4'b1100, 32'h0,        32'hFFFF_80FF, 5'd0, 2);
    tbl[7]  = mk(1, 0, 2'd1, 0, 32'h0000_1000, 32'h0,        5'd0, 32'h80FF_7F01, 0, 4'b0011, 32'h0,        32'h0000_7F01, 5'd0, 2);
    tbl[8]  = mk(0, 1, 2'd0, 0, 32'h0000_4001, 32'h0000_00A5, 5'd0, 32'h0,        0, 4'b0010, 32'hA5A5_A5A5, 32'h0,        5'd0, 2);
    tbl[9]  = mk(1, 0, 2'd2, 0, 32'h0000_5000, 32'h0,        5'd10, 32'h0,       0, 4'b0000, 32'h0,        32'h0,        5'd10, 0);
    tbl[10] = mk(1, 0, 2'd1, 0, 32'h0000_5001, 32'h0,        5'd3, 32'h0,        0, 4'b0000, 32'h0,        32'h0,        5'd3, 0);
    tbl[11] = mk(1, 0, 2'd2, 0, 32'h0000_6000, 32'h0,        5'd0, 32'h1111_1111, 8, 4'b1111, 32'h0,        32'h0,        5'd7, 8);
    tbl[12] = mk(1, 0, 2'd2, 0, 32'h0000_6100, 32'h0,        5'd0, 32'h0123_4567, 6, 4'b1111, 32'h0,        32'h0123_4567, 5'd0, 8);
    tbl[13] = mk(1, 1'b0, 2'd0, 1, 32'h0000_1001, 32'h0,     5'd0, 32'h80FF_7F01, 0, 4'b0010, 32'h0,        32'h0000_007F, 5'd0, 2);
    tbl[14] = mk(0, 0, 2'd2, 0, 32'h0000_7000, 32'h0,        5'd0, 32'h0,        0, 4'b0000, 32'h0,        32'h0,        5'd0, 0);

    repeat (2) @(posedge clk);
    #1;
    mem_rd = 1'b1; addr_m = 32'h0000_1004; mem_size = 2'd2;
    #1;
    chk("stall_in_reset", 32'(stall_m), 32'd0);
    chk("req_reset", 32'(bus_req), 32'd0);
    chk("ldv_reset", 32'(ld_valid), 32'd0);
    chk("ldd_reset", ld_data, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; mem_rd = 1'b0;

    for (int i = 0; i < 15; i++) run_op(tbl[i], 0);

    // flush in IDLE: op is not issued
    mem_rd = 1'b1; mem_size = 2'd2; addr_m = 32'h0000_1004; flush = 1'b1;
    #1;
    chk("stall_flush_idle", 32'(stall_m), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; mem_rd = 1'b0;
    #1;
    chk("req_flush_idle", 32'(bus_req), 32'd0);
    @(posedge clk); #1;

    // flush in first BUSY cycle, ack two cycles later: bus held, load suppressed
    run_op(tbl[0], 1);

    // reset while BUSY abandons the transaction
    mem_rd = 1'b1; mem_size = 2'd2; addr_m = 32'h0000_7000;
    @(posedge clk); #1;
    chk("req_pre_rst", 32'(bus_req), 32'd1);
    reset = 1'b1;
    #1;
    chk("stall_rst_busy", 32'(stall_m), 32'd0);
    @(posedge clk); #1;
    chk("req_post_rst", 32'(bus_req), 32'd0);
    reset = 1'b0; mem_rd = 1'b0;
    #1;
    chk("stall_post_rst", 32'(stall_m), 32'd0);
    run_op(tbl[1], 0);

    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 9);
      rv.rd   = (op < 5);
      rv.wr   = (op >= 5 && op < 9);
      rv.size = 2'($urandom_range(0, 2));
      rv.sign = 1'($urandom_range(0, 1));
      rv.addr = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (rv.size == 2'd1) rv.addr[0] = 1'b0;
        if (rv.size == 2'd2) rv.addr[1:0] = 2'b00;
      end
      rv.wdata  = $urandom;
      rv.rdata  = $urandom;
      rv.exc_in = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      rv.ack_delay = $urandom_range(0, 8);
      rv = model(rv);
      fc = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      run_op(rv, fc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
